// File: rtl/conv1_layer1_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package : conv_sched_pkg
// Purpose : Shared types, default timing constants and sizing helpers for
//           the conv1/layer1 dense-datapath sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package conv_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_SETUP    = 3'd2,
    ST_REQ      = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_GAP      = 3'd5,
    ST_FIN      = 3'd6
  } state_t;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_GAP_CYC   = 10;
  localparam int DEF_TO_CYC    = 1024;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Bits needed to hold values 0..max_val, never less than 1.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv1_layer1_sched_dcnt.sv
`default_nettype none
// ============================================================================
// Module  : sched_dcnt
// Purpose : Loadable saturating down-counter with an expiry flag. Shared by
//           the SETUP, GAP and WAIT_ACK phases of the sequencer.
// Ports   : clk, rst      - clock, async active-high reset
//           load/load_val - synchronous load (has priority over dec)
//           dec           - decrement by one, saturating at zero
//           expired       - count is at its last cycle (<= 1)
// Rev     : 1.0  initial release
// ============================================================================
module sched_dcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Expiry is flagged on the final counted cycle so the owning state can
  // leave on that same edge; a count of 0 means "leave immediately".
  assign expired = (r_cnt <= W'(1));

endmodule
`default_nettype wire

// File: rtl/conv1_layer1_sched.sv
`default_nettype none
// ============================================================================
// Module  : conv1_layer1_sched
// Purpose : Sequencer for the conv1/layer1 dense datapath. A host go pulse
//           starts a pass: one start pulse, a setup wait, then one paced
//           need_data request per row, each acknowledged before the next.
// Ports   : clk, rst (async, active-high)
//           go, cfg_rows          - host pass request / row count
//           buf_rdy, row_ack      - datapath handshake inputs
//           start, need_data      - one-cycle datapath strobes
//           busy, done, err       - pass status (err is sticky per pass)
//           row_idx               - rows acknowledged in this pass
// Rev     : 1.0  initial release
// ============================================================================
module conv1_layer1_sched
  import conv_sched_pkg::*;
#(
  parameter int ROW_W     = 8,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int TO_CYC    = DEF_TO_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic             buf_rdy,
  input  logic             row_ack,
  output logic             start,
  output logic             need_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ROW_W-1:0] row_idx
);

  localparam int CNT_W = cnt_width(max_of3(SETUP_CYC, GAP_CYC, TO_CYC + 1));

  // Load values are chosen so each phase's idle span matches the cycle
  // counts seen at the outputs: the REQ cycle itself absorbs one cycle of
  // SETUP and GAP, while WAIT_ACK includes the need_data cycle.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TO_CYC + 1);

  state_t           r_state;
  logic [ROW_W-1:0] r_cfg;

  logic             w_ld;
  logic [CNT_W-1:0] w_ld_val;
  logic             w_dec;
  logic             w_expired;
  logic             w_ack_ok;
  logic             w_last;
  logic [ROW_W-1:0] w_idx_inc;

  // An ack arriving alongside the request strobe cannot be a response to it.
  assign w_ack_ok  = (r_state == ST_WAIT_ACK) && row_ack && !need_data;
  assign w_idx_inc = row_idx + ROW_W'(1);
  assign w_last    = (w_idx_inc == r_cfg);

  always_comb begin
    w_ld     = 1'b0;
    w_ld_val = '0;
    w_dec    = 1'b0;
    case (r_state)
      ST_START: begin
        w_ld     = 1'b1;
        w_ld_val = SETUP_LD;
      end
      ST_SETUP, ST_GAP: w_dec = 1'b1;
      ST_REQ: begin
        w_ld     = buf_rdy;
        w_ld_val = TO_LD;
      end
      ST_WAIT_ACK: begin
        if (w_ack_ok) begin
          w_ld     = 1'b1;
          w_ld_val = GAP_LD;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  sched_dcnt #(
    .W (CNT_W)
  ) u_dcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_ld),
    .load_val (w_ld_val),
    .dec      (w_dec),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cfg     <= '0;
      start     <= 1'b0;
      need_data <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      row_idx   <= '0;
    end else begin
      start     <= 1'b0;
      need_data <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_cfg   <= cfg_rows;
            row_idx <= '0;
            err     <= 1'b0;
            start   <= 1'b1;
            busy    <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cfg == '0) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_FIN;
          end else if (SETUP_CYC <= 1) begin
            r_state <= ST_REQ;
          end else begin
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_expired) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (buf_rdy) begin
            need_data <= 1'b1;
            r_state   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // Ack is checked first so a coincident timeout loses.
          if (w_ack_ok) begin
            row_idx <= w_idx_inc;
            if (w_last) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= ST_FIN;
            end else if (GAP_CYC <= 1) begin
              r_state <= ST_REQ;
            end else begin
              r_state <= ST_GAP;
            end
          end else if (w_expired) begin
            err     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_FIN;
          end
        end
        ST_GAP: begin
          if (w_expired) r_state <= ST_REQ;
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv1_layer1_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv1_layer1_sched
// Purpose : Directed self-checking bench for conv1_layer1_sched. Inputs are
//           driven and outputs sampled on the falling edge; cycle k of a
//           scenario is the k-th falling edge after go was driven.
// Rev     : 1.0  initial release
// ============================================================================
module tb_conv1_layer1_sched;

  logic       clk;
  logic       rst;
  logic       go;
  logic [7:0] cfg_rows;
  logic       buf_rdy;
  logic       row_ack;
  logic       start;
  logic       need_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] row_idx;

  int checks;
  int failures;

  conv1_layer1_sched #(
    .ROW_W     (8),
    .SETUP_CYC (2),
    .GAP_CYC   (10),
    .TO_CYC    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .cfg_rows  (cfg_rows),
    .buf_rdy   (buf_rdy),
    .row_ack   (row_ack),
    .start     (start),
    .need_data (need_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .row_idx   (row_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; cfg_rows = 8'd0; buf_rdy = 1'b0; row_ack = 1'b0;
    idle_cycles(3);
    checks++;
    if ({start, need_data, busy, done, err, row_idx} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {start, need_data, busy, done, err, row_idx});
    end
    rst = 1'b0;
    idle_cycles(2);
    checks++;
    if ({start, need_data, busy, done, err, row_idx} !== 13'd0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=0", {start, need_data, busy, done, err, row_idx});
    end
  endtask

  // cfg_rows=3, ack 4 cycles after each request.
  task automatic test_three_rows();
    logic e_nd, e_done, e_start, e_busy;
    cfg_rows = 8'd3; buf_rdy = 1'b1; go = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      step();
      go = 1'b0; row_ack = 1'b0;
      e_start = (k == 1);
      e_nd    = (k == 4) || (k == 19) || (k == 34);
      e_done  = (k == 39);
      e_busy  = (k >= 1) && (k <= 38);
      checks++;
      if ({start, need_data, done, busy, err} !== {e_start, e_nd, e_done, e_busy, 1'b0}) begin
        failures++;
        $display("FAIL rows3 cyc=%0d got(start,nd,done,busy,err)=%b exp=%b",
                 k, {start, need_data, done, busy, err}, {e_start, e_nd, e_done, e_busy, 1'b0});
      end
      if (k == 8 || k == 23 || k == 38) row_ack = 1'b1;
    end
    checks++;
    if (row_idx !== 8'd3) begin
      failures++;
      $display("FAIL rows3_row_idx got=%0d exp=3", row_idx);
    end
  endtask

  task automatic test_zero_rows();
    cfg_rows = 8'd0; buf_rdy = 1'b1; go = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      go = 1'b0;
      checks++;
      if ({start, need_data, done, busy} !== {(k == 1), 1'b0, (k == 2), (k == 1)}) begin
        failures++;
        $display("FAIL rows0 cyc=%0d got(start,nd,done,busy)=%b exp=%b",
                 k, {start, need_data, done, busy}, {(k == 1), 1'b0, (k == 2), (k == 1)});
      end
    end
  endtask

  // buf_rdy low through 20 REQ cycles (cycles 3..22), rises in cycle 23.
  task automatic test_buf_rdy_hold();
    cfg_rows = 8'd1; buf_rdy = 1'b0; go = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      go = 1'b0; row_ack = 1'b0;
      checks++;
      if ({need_data, done} !== {(k == 24), (k == 27)}) begin
        failures++;
        $display("FAIL bufrdy cyc=%0d got(nd,done)=%b exp=%b",
                 k, {need_data, done}, {(k == 24), (k == 27)});
      end
      if (k == 23) buf_rdy = 1'b1;
      if (k == 26) row_ack = 1'b1;
    end
    checks++;
    if (row_idx !== 8'd1) begin
      failures++;
      $display("FAIL bufrdy_row_idx got=%0d exp=1", row_idx);
    end
  endtask

  // No ack: request at 4, err and done at 4+16+1.
  task automatic test_timeout();
    cfg_rows = 8'd2; buf_rdy = 1'b1; go = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      go = 1'b0;
      checks++;
      if ({need_data, done, err} !== {(k == 4), (k == 21), (k >= 21)}) begin
        failures++;
        $display("FAIL timeout cyc=%0d got(nd,done,err)=%b exp=%b",
                 k, {need_data, done, err}, {(k == 4), (k == 21), (k >= 21)});
      end
    end
    cfg_rows = 8'd0; go = 1'b1;
    step();
    go = 1'b0;
    checks++;
    if ({start, err} !== 2'b10) begin
      failures++;
      $display("FAIL timeout_err_clear got(start,err)=%b exp=10", {start, err});
    end
    idle_cycles(3);
  endtask

  // Stray acks (SETUP, same cycle as need_data, GAP), a second go while
  // busy, and two acks coincident with the timeout edge.
  task automatic test_ignored_inputs();
    cfg_rows = 8'd2; buf_rdy = 1'b1; go = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      step();
      go = 1'b0; row_ack = 1'b0; cfg_rows = 8'd2;
      checks++;
      if ({start, need_data, done, err} !== {(k == 1), (k == 4 || k == 31), (k == 48), 1'b0}) begin
        failures++;
        $display("FAIL ignore cyc=%0d got(start,nd,done,err)=%b exp=%b",
                 k, {start, need_data, done, err}, {(k == 1), (k == 4 || k == 31), (k == 48), 1'b0});
      end
      if (k == 2) begin row_ack = 1'b1; go = 1'b1; cfg_rows = 8'd5; end
      if (k == 4 || k == 20 || k == 23 || k == 47) row_ack = 1'b1;
    end
    checks++;
    if (row_idx !== 8'd2) begin
      failures++;
      $display("FAIL ignore_row_idx got=%0d exp=2", row_idx);
    end
  endtask

  task automatic test_reset_mid_pass();
    cfg_rows = 8'd3; buf_rdy = 1'b1; go = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      go = 1'b0; row_ack = 1'b0;
      if (k == 8) row_ack = 1'b1;
    end
    checks++;
    if ({busy, row_idx} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL midrst_before got(busy,row_idx)=%b exp=%b", {busy, row_idx}, {1'b1, 8'd1});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({start, need_data, busy, done, err, row_idx} !== 13'd0) begin
      failures++;
      $display("FAIL midrst_async got=%b exp=0", {start, need_data, busy, done, err, row_idx});
    end
    step();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if ({done, busy, need_data} !== 3'b000) begin
        failures++;
        $display("FAIL midrst_quiet cyc=%0d got(done,busy,nd)=%b exp=000", k, {done, busy, need_data});
      end
    end
    cfg_rows = 8'd1; go = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      go = 1'b0; row_ack = 1'b0;
      if (k == 1) begin
        checks++;
        if ({start, row_idx} !== {1'b1, 8'd0}) begin
          failures++;
          $display("FAIL restart_first got(start,row_idx)=%b exp=%b", {start, row_idx}, {1'b1, 8'd0});
        end
      end
      if (k == 7) begin
        checks++;
        if ({done, row_idx} !== {1'b1, 8'd1}) begin
          failures++;
          $display("FAIL restart_done got(done,row_idx)=%b exp=%b", {done, row_idx}, {1'b1, 8'd1});
        end
      end
      if (k == 6) row_ack = 1'b1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_three_rows();
    idle_cycles(2);
    test_zero_rows();
    test_buf_rdy_hold();
    idle_cycles(2);
    test_timeout();
    test_ignored_inputs();
    idle_cycles(2);
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
